vector_apu_dispatcher: RTL and testbench
========================================

Name: vector_apu_dispatcher

Overview:
- Core-side initiator of the APU request/response interface; it is the opposite end of the accelerator's vector decoder.
- Accepts vector instructions and their scalar operands from the core pipeline, buffers them in a small FIFO, and issues them one at a time (apu_req/apu_gnt).
- Waits for apu_rvalid to retire each one, and returns scalar results (vsetvli, vmv.x.s) to the core register-file writeback port.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=1).
- TIMEOUT_CYCLES, 64, cycles in REQ or WAIT_RSP before timeout_o sets.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid_i  in  1  core offers an instruction
- instr_ready_o  out  1  dispatcher accepts (= FIFO not full)
- instr_i  in  32  vector instruction word
- rs1_value_i  in  32  scalar operand 1
- rs2_value_i  in  32  scalar operand 2
- rd_addr_i  in  5  scalar destination register
- flags_i  in  15  APU flags for this instruction
- flush_i  in  1  discard queued (not in-flight) instructions
- apu_req  out  1  request to accelerator
- apu_gnt  in  1  accelerator grant
- apu_operands  out  3x32  [0]=instr, [1]=rs1, [2]=rs2
- apu_op  out  6  instr[31:26]
- apu_flags_o  out  15  flags of the issued entry
- apu_rvalid  in  1  accelerator completion
- apu_result  in  32  accelerator scalar result
- wb_valid_o  out  1  scalar writeback pending
- wb_ready_i  in  1  core accepts writeback
- wb_addr_o  out  5  writeback register
- wb_data_o  out  32  writeback value
- busy_o  out  1  FIFO non-empty, or state != IDLE, or wb_valid_o
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE; FIFO empty; apu_req=0, apu_operands/apu_op/apu_flags_o=0; wb_valid_o=0, wb_addr_o=0, wb_data_o=0; timeout_o=0; watchdog=0. Reset mid-transaction abandons the in-flight instruction; the system resets the accelerator with it.
- All outputs are registered except instr_ready_o (=!full) and busy_o.
- Push: instr_valid_i & instr_ready_o stores {instr, rs1, rs2, rd, flags, writes_rd}.
- writes_rd = (opcode==V_MAJOR_OP_V) & ((funct3==V_OPCFG & rd!=0) | (funct3==V_OPMVV & funct6==6'b010000 & rd!=0)).
- FSM:
  - IDLE: if FIFO non-empty & !wb_valid_o & !flush_i, pop the head into the issue register, set apu_req=1 → REQ.
  - REQ: outputs held stable while apu_req=1. On apu_gnt=1, clear apu_req → WAIT_RSP.
  - WAIT_RSP: on apu_rvalid=1:
    - if writes_rd, capture wb_data_o=apu_result, wb_addr_o=rd and set wb_valid_o;
    - → IDLE.
- apu_rvalid in IDLE/REQ is ignored; it is an assertion failure in simulation.
- Exactly one instruction is outstanding. The next issue waits until wb_valid_o has drained, so the result register is always free at rvalid.
- wb_valid_o is held until wb_ready_i; it clears on the cycle wb_valid_o & wb_ready_i.
- Latency: push at edge N → apu_req high after N+1. If gnt is in the same cycle → WAIT_RSP after N+2. rvalid in that cycle → wb_valid_o high after N+3. Back-to-back non-writing instructions issue every 3 cycles minimum.
- Simultaneous push and pop: allowed; the count is unchanged. When full, instr_ready_o=0 even if a pop happens in the same cycle (no bypass).
- flush_i: empties the FIFO the same cycle and blocks any IDLE pop that cycle. A push coinciding with flush_i is dropped. The in-flight REQ/WAIT_RSP instruction and a pending wb are unaffected.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
- Watchdog:
  - Counts while state is REQ or WAIT_RSP and clears on every state change.
  - When it reaches TIMEOUT_CYCLES-1, timeout_o sets and stays set until reset.
  - The FSM keeps waiting and never aborts.
  - The counter saturates.

Decomposition:
- accelerator_pkg gains:
  - apu_disp_state_t {IDLE, REQ, WAIT_RSP};
  - V_FUNCT6_VWXUNARY0 = 6'b010000;
  - typedef apu_disp_entry_t (instr, rs1, rs2, rd, flags, writes_rd).
- Existing V_MAJOR_OP_V, V_OPCFG and V_OPMVV are reused.
- One sub-module: apu_instr_fifo, a generic synchronous FIFO with push, pop, flush, full and empty, parameterised on depth and entry type.

Test Plan:
- Single vsetvli (instr 0x0C207057 with rd=x10 set to 5; rs1=8), gnt same cycle as req, rvalid one cycle later with result 8 → apu_operands[0]=0x0C207057 while req; wb_valid_o=1, wb_addr_o=10, wb_data_o=8 three cycles after push.
- vadd.vv (no rd writeback), gnt delayed 3 cycles, rvalid after 4 more → apu_req held stable 4 cycles, operands unchanged, no wb_valid_o, busy_o drops after rvalid.
- Fill FIFO_DEPTH=2 while first instruction waits on rvalid → third push sees instr_ready_o=0; entries issue in push order with correct rs1/rs2 pairing.
- vmv.x.s result 0xDEADBEEF with wb_ready_i=0 for 5 cycles and a queued instruction behind it → wb_valid_o held 5 cycles, no apu_req until the wb handshake completes.
- flush_i with 2 queued entries while one is in WAIT_RSP → FIFO empty, in-flight instruction retires normally, no further apu_req.
- Withhold apu_gnt for 64 cycles → timeout_o=1 on the 64th cycle and stays 1 after a late gnt/rvalid; reset clears it and all outputs are 0.

Source files
------------

// File: rtl/vector_apu_dispatcher_pkg.sv
// Shared types and decode constants for the core-side APU dispatcher.
package vector_apu_dispatcher_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned FLAGS_W    = 15;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [6:0] V_MAJOR_OP_V       = 7'b1010111;
    localparam logic [2:0] V_OPCFG            = 3'b111;
    localparam logic [2:0] V_OPMVV            = 3'b010;
    localparam logic [5:0] V_FUNCT6_VWXUNARY0 = 6'b010000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } apu_disp_state_t;

    typedef struct packed {
        logic [XLEN-1:0]       instr;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [FLAGS_W-1:0]    flags;
        logic                  writes_rd;
    } apu_disp_entry_t;

    // vsetvli-family and vmv.x.s return a scalar to a non-zero rd.
    function automatic logic is_scalar_writer(input logic [XLEN-1:0] instr,
                                              input logic [REG_ADDR_W-1:0] rd);
        logic cfg;
        logic mvxs;
        cfg  = (instr[14:12] == V_OPCFG);
        mvxs = (instr[14:12] == V_OPMVV) && (instr[31:26] == V_FUNCT6_VWXUNARY0);
        return (instr[6:0] == V_MAJOR_OP_V) && (rd != '0) && (cfg || mvxs);
    endfunction

endpackage

// File: rtl/vector_apu_dispatcher_fifo.sv
// Generic synchronous FIFO with flush; extra pointer bit distinguishes full from empty.
module apu_instr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  entry_t data_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W  = ADDR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p[ADDR_W-1:0] == ADDR_W'(DEPTH - 1)) begin
            return {~p[ADDR_W], ADDR_W'(0)};
        end
        return p + PTR_W'(1);
    endfunction

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Flush wins over both push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push_i && !full_o)  wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i  && !empty_o) rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o && !flush_i) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vector_apu_dispatcher.sv
// Core-side APU initiator: queues vector instructions, issues one at a time, returns scalar results.
module vector_apu_dispatcher #(
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      rs1_value_i,
    input  logic [31:0]      rs2_value_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [14:0]      flags_i,
    input  logic             flush_i,
    output logic             apu_req,
    input  logic             apu_gnt,
    output logic [2:0][31:0] apu_operands,
    output logic [5:0]       apu_op,
    output logic [14:0]      apu_flags_o,
    input  logic             apu_rvalid,
    input  logic [31:0]      apu_result,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_addr_o,
    output logic [31:0]      wb_data_o,
    output logic             busy_o,
    output logic             timeout_o
);

    import vector_apu_dispatcher_pkg::*;

    localparam int unsigned       WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);

    apu_disp_state_t       state_q, state_d;
    apu_disp_entry_t       issue_q, issue_d;
    apu_disp_entry_t       push_entry, head_entry;
    logic                  apu_req_q, apu_req_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  timeout_q, timeout_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop;

    always_comb begin
        push_entry = '{instr: instr_i, rs1: rs1_value_i, rs2: rs2_value_i, rd: rd_addr_i,
                       flags: flags_i, writes_rd: is_scalar_writer(instr_i, rd_addr_i)};
    end

    assign push = instr_valid_i && !fifo_full && !flush_i;
    // Issue only with the writeback register free, so retirement never stalls.
    assign pop  = (state_q == IDLE) && !fifo_empty && !wb_valid_q && !flush_i;

    apu_instr_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (apu_disp_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        apu_req_d  = apu_req_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        timeout_d  = timeout_q;
        wdog_d     = wdog_q;

        if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    issue_d   = head_entry;
                    apu_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (apu_gnt) begin
                    apu_req_d = 1'b0;
                    state_d   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (apu_rvalid) begin
                    if (issue_q.writes_rd) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = issue_q.rd;
                        wb_data_d  = apu_result;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: restarts on any state change, saturates, and only ever flags.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q != IDLE && wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
        if (state_q != IDLE && state_d == state_q && wdog_d == WDOG_MAX) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            apu_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            timeout_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            apu_req_q  <= apu_req_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            timeout_q  <= timeout_d;
            wdog_q     <= wdog_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && apu_rvalid) begin
            assert (state_q == WAIT_RSP) else $error("apu_rvalid outside WAIT_RSP");
        end
    end

    assign instr_ready_o = !fifo_full;
    assign busy_o        = !fifo_empty || (state_q != IDLE) || wb_valid_q;
    assign apu_req       = apu_req_q;
    assign apu_operands  = {issue_q.rs2, issue_q.rs1, issue_q.instr};
    assign apu_op        = issue_q.instr[31:26];
    assign apu_flags_o   = issue_q.flags;
    assign wb_valid_o    = wb_valid_q;
    assign wb_addr_o     = wb_addr_q;
    assign wb_data_o     = wb_data_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_vector_apu_dispatcher.sv
// Bench for vector_apu_dispatcher: transaction-level queue model checked every cycle, directed plus random stimulus.
`timescale 1ns/1ps
module tb_vector_apu_dispatcher;

    localparam int DEPTH = 2;
    localparam int TMO   = 64;
    localparam logic [31:0] VSETVLI = 32'h0C207057;
    localparam logic [31:0] VMVXS   = 32'h42002057;
    localparam logic [31:0] VADD    = 32'h02208057;

    logic clk = 1'b0;
    logic reset, instr_valid_i, instr_ready_o, flush_i;
    logic [31:0] instr_i, rs1_value_i, rs2_value_i, apu_result, wb_data_o;
    logic [4:0] rd_addr_i, wb_addr_o;
    logic [14:0] flags_i, apu_flags_o;
    logic apu_req, apu_gnt, apu_rvalid, wb_valid_o, wb_ready_i, busy_o, timeout_o;
    logic [2:0][31:0] apu_operands;
    logic [5:0] apu_op;

    always #5 clk = ~clk;

    vector_apu_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i),
        .rd_addr_i(rd_addr_i), .flags_i(flags_i), .flush_i(flush_i),
        .apu_req(apu_req), .apu_gnt(apu_gnt), .apu_operands(apu_operands), .apu_op(apu_op),
        .apu_flags_o(apu_flags_o), .apu_rvalid(apu_rvalid), .apu_result(apu_result),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [14:0] flags;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    bit m_infl, m_gnt, m_req, m_wbv, m_tmo, started, acc, wb_was;
    logic [4:0] m_wba;
    logic [31:0] m_wbd;
    int m_wd;
    int tests = 0;
    int fails = 0;

    function automatic bit returns_scalar(input ent_t e);
        return e.instr[6:0] == 7'h57 && e.rd != 0 &&
               (e.instr[14:12] == 3'b111 || (e.instr[14:12] == 3'b010 && e.instr[31:26] == 6'b010000));
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding instruction, a bounded queue, a pending-writeback slot.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur = '{default: 0};
            {m_infl, m_gnt, m_req, m_wbv, m_tmo} = '0;
            m_wba = 0; m_wbd = 0; m_wd = 0;
            started = 1;
        end else if (started) begin
            acc = instr_valid_i && q.size() < DEPTH && !flush_i;
            wb_was = m_wbv;
            if (m_wbv && wb_ready_i) m_wbv = 0;
            if (!m_infl) begin
                if (q.size() > 0 && !wb_was && !flush_i) begin
                    cur = q.pop_front();
                    m_infl = 1; m_gnt = 0; m_req = 1; m_wd = 0;
                end
            end else if (!m_gnt && apu_gnt) begin
                m_gnt = 1; m_req = 0; m_wd = 0;
            end else if (m_gnt && apu_rvalid) begin
                m_infl = 0; m_wd = 0;
                if (returns_scalar(cur)) begin
                    m_wbv = 1; m_wba = cur.rd; m_wbd = apu_result;
                end
            end else begin
                if (m_wd < TMO - 1) m_wd++;
                if (m_wd == TMO - 1) m_tmo = 1;
            end
            if (flush_i) q.delete();
            if (acc) q.push_back('{instr_i, rs1_value_i, rs2_value_i, rd_addr_i, flags_i});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", instr_ready_o, q.size() < DEPTH);
            chk("busy", busy_o, q.size() > 0 || m_infl || m_wbv);
            chk("req", apu_req, m_req);
            chk("operands", apu_operands, {cur.rs2, cur.rs1, cur.instr});
            chk("op", apu_op, cur.instr[31:26]);
            chk("flags", apu_flags_o, cur.flags);
            chk("wb_valid", wb_valid_o, m_wbv);
            chk("wb_addr", wb_addr_o, m_wba);
            chk("wb_data", wb_data_o, m_wbd);
            chk("timeout", timeout_o, m_tmo);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] rd);
        instr_valid_i = 1; instr_i = ins; rs1_value_i = r1; rs2_value_i = r2;
        rd_addr_i = rd; flags_i = 15'($urandom);
        tick();
        instr_valid_i = 0;
    endtask

    // Pulse rvalid once the outstanding instruction has been granted (bounded wait).
    task automatic retire(input logic [31:0] res);
        int k = 0;
        while (!(m_infl && m_gnt) && k < 100) begin tick(); k++; end
        tests++;
        if (!(m_infl && m_gnt)) begin
            fails++;
            $display("FAIL retire_wait: no granted instruction after %0d cycles", k);
        end else begin
            apu_rvalid = 1; apu_result = res;
            tick();
            apu_rvalid = 0;
        end
    endtask

    initial begin
        reset = 1; instr_valid_i = 0; instr_i = 0; rs1_value_i = 0; rs2_value_i = 0;
        rd_addr_i = 0; flags_i = 0; flush_i = 0; apu_gnt = 0; apu_rvalid = 0;
        apu_result = 0; wb_ready_i = 0;
        tick(2);
        chk("rst_req", apu_req, 0);
        chk("rst_ops", apu_operands, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        reset = 0;

        // vsetvli with immediate grant and rvalid: writeback 3 cycles after push
        apu_gnt = 1; wb_ready_i = 1;
        offer(VSETVLI, 32'd8, 32'd0, 5'd10);
        tick();
        chk("t1_req", apu_req, 1);
        chk("t1_op0", apu_operands[0], VSETVLI);
        chk("t1_apu_op", apu_op, 6'h03);
        tick();
        apu_rvalid = 1; apu_result = 32'd8;
        tick();
        apu_rvalid = 0;
        chk("t1_wbv", wb_valid_o, 1);
        chk("t1_wba", wb_addr_o, 10);
        chk("t1_wbd", wb_data_o, 8);
        tick(2);

        // vadd.vv with delayed grant: request held stable, no writeback
        apu_gnt = 0;
        offer(VADD, 32'h1111_0001, 32'h2222_0002, 5'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_req", apu_req, 1);
            chk("t2_op0", apu_operands[0], VADD);
        end
        apu_gnt = 1; tick(); apu_gnt = 0;
        chk("t2_req_drop", apu_req, 0);
        tick(3);
        apu_rvalid = 1; tick(); apu_rvalid = 0;
        chk("t2_wbv", wb_valid_o, 0);
        chk("t2_busy", busy_o, 0);

        // fill the queue behind a waiting instruction; order and rs pairing preserved
        apu_gnt = 1;
        offer(VADD, 32'hA1, 32'hA2, 5'd1);
        offer(VADD, 32'hB1, 32'hB2, 5'd2);
        offer(VADD, 32'hC1, 32'hC2, 5'd3);
        chk("t3_full", instr_ready_o, 0);
        offer(VADD, 32'hD1, 32'hD2, 5'd4);
        retire(32'h0);
        tick();
        chk("t3_b_rs1", apu_operands[1], 32'hB1);
        chk("t3_b_rs2", apu_operands[2], 32'hB2);
        retire(32'h0);
        tick();
        chk("t3_c_rs1", apu_operands[1], 32'hC1);
        retire(32'h0);
        tick(3);
        chk("t3_idle", busy_o, 0);

        // vmv.x.s result stalled by wb_ready with an instruction queued behind it
        wb_ready_i = 0;
        offer(VMVXS, 32'h0, 32'h0, 5'd7);
        offer(VADD, 32'hE1, 32'hE2, 5'd0);
        retire(32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            chk("t4_wbv", wb_valid_o, 1);
            chk("t4_wbd", wb_data_o, 32'hDEADBEEF);
            chk("t4_wba", wb_addr_o, 7);
            chk("t4_noreq", apu_req, 0);
            tick();
        end
        wb_ready_i = 1; tick();
        chk("t4_wb_done", wb_valid_o, 0);
        chk("t4_still_noreq", apu_req, 0);
        tick();
        chk("t4_next_req", apu_req, 1);
        chk("t4_next_rs1", apu_operands[1], 32'hE1);
        retire(32'h0);
        tick(2);

        // flush two queued entries while one waits for rvalid
        offer(VADD, 32'hF1, 32'hF2, 5'd1);
        offer(VADD, 32'hF3, 32'hF4, 5'd2);
        offer(VADD, 32'hF5, 32'hF6, 5'd3);
        flush_i = 1; tick(); flush_i = 0;
        chk("t5_ready", instr_ready_o, 1);
        chk("t5_busy_inflight", busy_o, 1);
        retire(32'h0);
        tick(3);
        chk("t5_noreq", apu_req, 0);
        chk("t5_idle", busy_o, 0);

        // watchdog: grant withheld 64 cycles
        apu_gnt = 0;
        offer(VADD, 32'h77, 32'h88, 5'd0);
        for (int i = 1; i <= TMO; i++) begin
            tick();
            chk("t6_tmo", timeout_o, (i == TMO) ? 1'b1 : 1'b0);
        end
        tick(3);
        apu_gnt = 1;
        retire(32'h0);
        tick();
        chk("t6_sticky", timeout_o, 1);
        reset = 1; tick();
        chk("t6_rst_tmo", timeout_o, 0);
        chk("t6_rst_req", apu_req, 0);
        chk("t6_rst_ops", apu_operands, 0);
        chk("t6_rst_wb", {wb_valid_o, wb_addr_o, wb_data_o}, 0);
        reset = 0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int k;
            reset = ($urandom_range(0, 999) == 0);
            instr_valid_i = $urandom_range(0, 1) != 0;
            k = $urandom_range(0, 3);
            instr_i = (k == 0) ? VSETVLI : (k == 1) ? VMVXS : (k == 2) ? VADD : 32'($urandom);
            rs1_value_i = $urandom; rs2_value_i = $urandom;
            rd_addr_i = 5'($urandom_range(0, 31)); flags_i = 15'($urandom);
            flush_i = ($urandom_range(0, 19) == 0);
            apu_gnt = $urandom_range(0, 2) != 0;
            apu_rvalid = m_infl && m_gnt && ($urandom_range(0, 2) == 0);
            apu_result = $urandom;
            wb_ready_i = $urandom_range(0, 1) != 0;
            tick();
        end
        instr_valid_i = 0; apu_rvalid = 0; flush_i = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
